vga_sync: RTL and testbench

Raster timing generator for the 1280x1024 @ 60 Hz VGA output. It sits directly upstream of the cell-colouring stage and drives that stage's `x` and `y` pixel coordinates. It also supplies the monitor's `hsync` and `vsync`, plus a `video_on` blanking qualifier. A once-per-generation `gen_tick` tells the Life engine when to compute the next board, so `alive` and `alive_prev` change only at frame boundaries.

---
 rtl/vga_pkg.sv | 43 ++++
 rtl/mod_counter.sv | 44 ++++
 rtl/vga_sync.sv | 121 ++++++++++++
 tb/tb_vga_sync.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared raster timing constants and helpers for vga_sync
// Purpose: default 1280x1024 @ 60 Hz timing, derived totals and sync windows,
// coordinate width, and small helpers shared by the raster generator.
// Ports: none (package).
package vga_pkg;

    localparam int COORD_W = 11;
    localparam int FRAME_W = 8;

    localparam int H_VISIBLE_DEF = 1280;
    localparam int H_FP_DEF      = 48;
    localparam int H_SYNC_DEF    = 112;
    localparam int H_BP_DEF      = 248;

    localparam int V_VISIBLE_DEF = 1024;
    localparam int V_FP_DEF      = 1;
    localparam int V_SYNC_DEF    = 3;
    localparam int V_BP_DEF      = 38;

    localparam int GEN_FRAMES_DEF = 30;

    localparam int H_TOTAL_DEF      = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF      = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int H_SYNC_START_DEF = H_VISIBLE_DEF + H_FP_DEF;
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
    localparam int V_SYNC_START_DEF = V_VISIBLE_DEF + V_FP_DEF;
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

    // Inclusive window test on a coordinate.
    function automatic logic in_window(
        input logic [COORD_W-1:0] v,
        input logic [COORD_W-1:0] lo,
        input logic [COORD_W-1:0] hi
    );
        return (v >= lo) && (v <= hi);
    endfunction

    // Map an "in sync window" flag onto the configured sync polarity.
    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - enabled modulo-N counter with registered wrap pulse
// Purpose: counts 0..MODULUS-1 on enabled cycles, synchronous active-high reset.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   en              - advance enable
//   count           - registered count value
//   count_next      - value count takes at the next edge (for skew-free decode)
//   carry           - combinational: this enabled cycle wraps the counter
//   wrap            - registered carry: high for one clk while 0 is first shown
module mod_counter #(
    parameter int MODULUS = 2,
    parameter int WIDTH   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next,
    output logic             carry,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    always_comb begin
        carry      = en && (count == LAST);
        count_next = count;
        if (en) begin
            count_next = carry ? '0 : count + WIDTH'(1);
        end
    end

    // wrap follows carry every clk, so it self-clears even when en stays low.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_next;
            wrap  <= carry;
        end
    end

endmodule

// File: rtl/vga_sync.sv
// rtl/vga_sync.sv - raster timing generator with generation tick for the Life engine
// Purpose: produces pixel coordinates, syncs, blanking and frame/generation pulses.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   pix_en       - pixel-rate enable
//   pause        - freezes generation stepping (sampled on the raster wrap)
//   x, y         - current column / line
//   hsync, vsync - syncs at SYNC_POL when active
//   video_on     - x and y both inside the visible area
//   frame_start  - one-clk pulse when (0,0) is first shown after a wrap
//   gen_tick     - one-clk pulse with frame_start on each generation boundary
module vga_sync
    import vga_pkg::*;
#(
    parameter int   H_VISIBLE  = H_VISIBLE_DEF,
    parameter int   H_FP       = H_FP_DEF,
    parameter int   H_SYNC     = H_SYNC_DEF,
    parameter int   H_BP       = H_BP_DEF,
    parameter int   V_VISIBLE  = V_VISIBLE_DEF,
    parameter int   V_FP       = V_FP_DEF,
    parameter int   V_SYNC     = V_SYNC_DEF,
    parameter int   V_BP       = V_BP_DEF,
    parameter logic SYNC_POL   = 1'b1,
    parameter int   GEN_FRAMES = GEN_FRAMES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    input  logic               pause,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               frame_start,
    output logic               gen_tick
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_VIS_C = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] V_VIS_C = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] H_SS_C  = COORD_W'(H_VISIBLE + H_FP);
    localparam logic [COORD_W-1:0] H_SE_C  = COORD_W'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] V_SS_C  = COORD_W'(V_VISIBLE + V_FP);
    localparam logic [COORD_W-1:0] V_SE_C  = COORD_W'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [COORD_W-1:0] x_next;
    logic [COORD_W-1:0] y_next;
    logic               x_carry;
    logic               x_wrap;
    logic               raster_wrap;
    logic               frame_en;
    logic [FRAME_W-1:0] frame_count;
    logic [FRAME_W-1:0] frame_next;
    logic               gen_carry;

    mod_counter #(
        .MODULUS (H_TOTAL),
        .WIDTH   (COORD_W)
    ) u_x (
        .clk        (clk),
        .rst        (rst),
        .en         (pix_en),
        .count      (x),
        .count_next (x_next),
        .carry      (x_carry),
        .wrap       (x_wrap)
    );

    // y steps in the same pix_en cycle that x wraps; its carry is the raster wrap.
    mod_counter #(
        .MODULUS (V_TOTAL),
        .WIDTH   (COORD_W)
    ) u_y (
        .clk        (clk),
        .rst        (rst),
        .en         (x_carry),
        .count      (y),
        .count_next (y_next),
        .carry      (raster_wrap),
        .wrap       (frame_start)
    );

    // pause only matters on the wrap cycle because that is the only cycle
    // in which the frame counter is ever enabled.
    assign frame_en = raster_wrap && !pause;

    mod_counter #(
        .MODULUS (GEN_FRAMES),
        .WIDTH   (FRAME_W)
    ) u_frame (
        .clk        (clk),
        .rst        (rst),
        .en         (frame_en),
        .count      (frame_count),
        .count_next (frame_next),
        .carry      (gen_carry),
        .wrap       (gen_tick)
    );

    // Qualifiers decode the coordinates being loaded this edge, so they are
    // registered alongside x/y and describe the same presented position.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync    <= ~SYNC_POL;
            vsync    <= ~SYNC_POL;
            video_on <= 1'b1;
        end else begin
            hsync    <= sync_level(in_window(x_next, H_SS_C, H_SE_C), SYNC_POL);
            vsync    <= sync_level(in_window(y_next, V_SS_C, V_SE_C), SYNC_POL);
            video_on <= (x_next < H_VIS_C) && (y_next < V_VIS_C);
        end
    end

    // Counter side outputs not needed at this level.
    logic unused_side;
    assign unused_side = ^{x_wrap, frame_count, frame_next, gen_carry};

endmodule

// File: tb/tb_vga_sync.sv
// tb/tb_vga_sync.sv - self-checking bench for vga_sync on a reduced raster
module tb_vga_sync;

    // Reduced geometry: line 25 (hsync x 18..20), frame 11 lines (vsync y 7..8).
    localparam int HV = 16, HF = 2, HS = 3, HB = 4;
    localparam int VV = 6, VF = 1, VS = 2, VB = 2;
    localparam int LINE = 25;
    localparam int FRAME = 275;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_en = 1'b0;
    logic        pause = 1'b0;
    logic [10:0] x, y;
    logic        hsync, vsync, video_on, frame_start, gen_tick;

    int checks = 0;
    int failures = 0;
    int fs_seen = 0;
    int gt_seen = 0;

    always #5 clk = ~clk;

    vga_sync #(
        .H_VISIBLE (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_VISIBLE (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL  (1'b1),
        .GEN_FRAMES(3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .pause       (pause),
        .x           (x),
        .y           (y),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .frame_start (frame_start),
        .gen_tick    (gen_tick)
    );

    typedef struct {
        int   n;
        int   ex;
        int   ey;
        logic ehs;
        logic evs;
        logic evon;
        logic efs;
    } vec_t;

    vec_t vecs[21];

    task automatic tick(input logic en);
        pix_en = en;
        @(negedge clk);
        if (frame_start) fs_seen++;
        if (gen_tick) gt_seen++;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pause = 1'b0;
        tick(1'b1);
        tick(1'b1);
        rst = 1'b0;
        fs_seen = 0;
        gt_seen = 0;
    endtask

    initial begin
        int cur;
        int vs_cnt, hs_cnt, von_cnt, fs_x, fs_y;

        //          n    x   y  hs vs von fs
        vecs[0]  = '{0,   0,  0, 0, 0, 1, 0};
        vecs[1]  = '{15,  15, 0, 0, 0, 1, 0};
        vecs[2]  = '{16,  16, 0, 0, 0, 0, 0};
        vecs[3]  = '{17,  17, 0, 0, 0, 0, 0};
        vecs[4]  = '{18,  18, 0, 1, 0, 0, 0};
        vecs[5]  = '{20,  20, 0, 1, 0, 0, 0};
        vecs[6]  = '{21,  21, 0, 0, 0, 0, 0};
        vecs[7]  = '{24,  24, 0, 0, 0, 0, 0};
        vecs[8]  = '{25,  0,  1, 0, 0, 1, 0};
        vecs[9]  = '{40,  15, 1, 0, 0, 1, 0};
        vecs[10] = '{41,  16, 1, 0, 0, 0, 0};
        vecs[11] = '{150, 0,  6, 0, 0, 0, 0};
        vecs[12] = '{174, 24, 6, 0, 0, 0, 0};
        vecs[13] = '{175, 0,  7, 0, 1, 0, 0};
        vecs[14] = '{193, 18, 7, 1, 1, 0, 0};
        vecs[15] = '{200, 0,  8, 0, 1, 0, 0};
        vecs[16] = '{224, 24, 8, 0, 1, 0, 0};
        vecs[17] = '{225, 0,  9, 0, 0, 0, 0};
        vecs[18] = '{274, 24, 10, 0, 0, 0, 0};
        vecs[19] = '{275, 0,  0, 0, 0, 1, 1};
        vecs[20] = '{276, 1,  0, 0, 0, 1, 0};

        // Reset state while rst is held.
        rst = 1'b1;
        tick(1'b1);
        tick(1'b1);
        check("rst.x", x, 0);
        check("rst.y", y, 0);
        check("rst.hsync", hsync, 0);
        check("rst.vsync", vsync, 0);
        check("rst.video_on", video_on, 1);
        check("rst.frame_start", frame_start, 0);
        check("rst.gen_tick", gen_tick, 0);

        // Table sweep through one frame from reset.
        do_reset();
        cur = 0;
        for (int i = 0; i < 21; i++) begin
            while (cur < vecs[i].n) begin
                tick(1'b1);
                cur++;
            end
            check($sformatf("vec%0d.x", i), x, vecs[i].ex);
            check($sformatf("vec%0d.y", i), y, vecs[i].ey);
            check($sformatf("vec%0d.hsync", i), hsync, vecs[i].ehs);
            check($sformatf("vec%0d.vsync", i), vsync, vecs[i].evs);
            check($sformatf("vec%0d.video_on", i), video_on, vecs[i].evon);
            check($sformatf("vec%0d.frame_start", i), frame_start, vecs[i].efs);
        end
        check("table.fs_count", fs_seen, 1);
        check("table.gt_count", gt_seen, 0);

        // Whole-frame occupancy counts.
        do_reset();
        vs_cnt = 0; hs_cnt = 0; von_cnt = 0; fs_x = -1; fs_y = -1;
        for (int i = 0; i < FRAME; i++) begin
            tick(1'b1);
            if (vsync) vs_cnt++;
            if (hsync) hs_cnt++;
            if (video_on) von_cnt++;
            if (frame_start) begin
                fs_x = x;
                fs_y = y;
            end
        end
        check("frame.vsync_cycles", vs_cnt, 2 * LINE);
        check("frame.hsync_cycles", hs_cnt, 3 * 11);
        check("frame.video_on_cycles", von_cnt, HV * VV);
        check("frame.fs_count", fs_seen, 1);
        check("frame.fs_x", fs_x, 0);
        check("frame.fs_y", fs_y, 0);

        // gen_tick every third wrap.
        do_reset();
        for (int w = 1; w <= 9; w++) begin
            repeat (FRAME) tick(1'b1);
            check($sformatf("gen.w%0d.frame_start", w), frame_start, 1);
            check($sformatf("gen.w%0d.gen_tick", w), gen_tick, (w % 3 == 0) ? 1 : 0);
        end
        check("gen.fs_count", fs_seen, 9);
        check("gen.gt_count", gt_seen, 3);

        // pause across wraps 4 and 5; a mid-frame pause blip in frame 7.
        do_reset();
        for (int w = 1; w <= 8; w++) begin
            repeat (100) tick(1'b1);
            if (w == 4) pause = 1'b1;
            if (w == 6) pause = 1'b0;
            if (w == 7) pause = 1'b1;
            repeat (100) tick(1'b1);
            if (w == 7) pause = 1'b0;
            repeat (FRAME - 200) tick(1'b1);
            check($sformatf("pause.w%0d.frame_start", w), frame_start, 1);
            check($sformatf("pause.w%0d.gen_tick", w), gen_tick, (w == 3 || w == 8) ? 1 : 0);
        end
        check("pause.fs_count", fs_seen, 8);
        check("pause.gt_count", gt_seen, 2);

        // pix_en one cycle in four.
        do_reset();
        for (int i = 0; i < 4 * FRAME; i++) begin
            tick((i % 4) == 0);
            if (i == 119) begin
                check("slow.x_at_30", x, 5);
                check("slow.y_at_30", y, 1);
            end
            if (i == 121) begin
                check("slow.x_hold", x, 6);
            end
        end
        check("slow.fs_width", fs_seen, 1);
        check("slow.gt_count", gt_seen, 0);
        check("slow.end_x", x, 0);
        check("slow.end_y", y, 0);

        // Mid-frame reset inside both sync windows, with frame counter at 2.
        do_reset();
        repeat (744) tick(1'b1);
        check("mrst.pre_x", x, 19);
        check("mrst.pre_y", y, 7);
        check("mrst.pre_hsync", hsync, 1);
        check("mrst.pre_vsync", vsync, 1);
        rst = 1'b1;
        tick(1'b1);
        rst = 1'b0;
        check("mrst.x", x, 0);
        check("mrst.y", y, 0);
        check("mrst.hsync", hsync, 0);
        check("mrst.vsync", vsync, 0);
        check("mrst.video_on", video_on, 1);
        check("mrst.frame_start", frame_start, 0);
        fs_seen = 0;
        gt_seen = 0;
        for (int w = 1; w <= 3; w++) begin
            repeat (FRAME) tick(1'b1);
            check($sformatf("mrst.w%0d.gen_tick", w), gen_tick, (w == 3) ? 1 : 0);
        end
        check("mrst.fs_count", fs_seen, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
